// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from the read side of a FIFO: fetches one word per frame
// and serialises it as start, LSB-first data, optional parity and stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  empty,
  output logic                  rd,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } state_t;

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
    return (^word) ^ PAR_ODD;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        baud_q, baud_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    stop_q, stop_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic [15:0]             count_q, count_d;
  logic                    armed_q;
  logic                    tx_q, tx_d;
  logic                    rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic                    baud_last_s;

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Next-state, counter and datapath decode
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        baud_d = {CNT_W{1'b0}};
        // armed_q holds off the first fetch for one edge after reset release
        if (armed_q && tx_en && !empty) begin
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d = rd_data;
        par_d   = parity_of(rd_data);
        baud_d  = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        stop_d  = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_last_s) begin
          baud_d  = {CNT_W{1'b0}};
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last_s) begin
          baud_d  = {CNT_W{1'b0}};
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      PAR: begin
        if (baud_last_s) begin
          baud_d  = {CNT_W{1'b0}};
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last_s) begin
          baud_d = {CNT_W{1'b0}};
          if (stop_q == STOP_LAST) begin
            stop_d  = 1'b0;
            count_d = count_q + 16'd1;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        stop_d  = 1'b0;
      end
    endcase
  end

  // Output pre-decode from the next state so outputs leave the flops glitch-free
  always_comb begin
    rd_d   = (state_d == RD);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      stop_q  <= 1'b0;
      shift_q <= {DATA_WIDTH{1'b0}};
      par_q   <= 1'b0;
      count_q <= 16'd0;
      armed_q <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      count_q <= count_d;
      armed_q <= 1'b1;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  assign tx          = tx_q;
  assign rd          = rd_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one FIFO word and of one serial data field.
REQ-002 Parameter CLKS_PER_BIT, default 16, range 2..65535: clk_rd cycles per serial bit.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1, range 1..2: number of stop bits.
REQ-005 Port clk_rd, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-007 Port tx_en, input, 1 bit: permits new frames to start.
REQ-008 Port empty, input, 1 bit: FIFO read-side empty flag.
REQ-009 Port rd, output, 1 bit: FIFO read strobe.
REQ-010 Port rd_data, input, DATA_WIDTH bits: FIFO read data, valid in the cycle after rd.
REQ-011 Port tx, output, 1 bit: serial line, idle high.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port frame_count, output, 16 bits: number of completed frames.

Function
REQ-014 The state machine SHALL have the states IDLE, RD, LATCH, START, DATA, PAR and STOP; tx and rd SHALL be registered or decoded from state only, never from inputs.
REQ-015 IDLE: tx=1, rd=0; if tx_en=1 and empty=0 at a rising edge, the next state SHALL be RD, otherwise the state stays IDLE.
REQ-016 RD: rd=1 for exactly one cycle; the next state SHALL be LATCH unconditionally.
REQ-017 LATCH: rd=0; at the end of this cycle rd_data SHALL be captured into the shift register, parity SHALL be computed from the captured word, and the next state SHALL be START.
REQ-018 rd SHALL never be asserted while empty=1 is sampled in IDLE, and SHALL never be asserted more than once per frame.
REQ-019 START: tx=0 for CLKS_PER_BIT cycles; the next state SHALL be DATA.
REQ-020 DATA: tx carries the shift-register bits LSB first, each for CLKS_PER_BIT cycles, DATA_WIDTH bits in total; the next state SHALL be PAR if PARITY≠0, otherwise STOP.
REQ-021 PAR: tx carries the parity bit for CLKS_PER_BIT cycles.
- Even parity: tx = XOR of the data bits.
- Odd parity: tx = its inverse.
REQ-022 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at the last cycle frame_count SHALL increment and the next state SHALL be IDLE.
REQ-023 Frame length from the first START cycle to the last STOP cycle SHALL be exactly (1+DATA_WIDTH+(PARITY≠0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 Latency SHALL be three rising edges: IDLE samples empty=0, then RD, then LATCH, then tx=0 in the first START cycle.
REQ-025 Back-to-back frames SHALL have exactly one IDLE cycle of tx=1 between the last STOP cycle and the following RD.
REQ-026 The baud counter SHALL have width ceil(log2(CLKS_PER_BIT)) and SHALL reset to 0 at every bit boundary; the bit index SHALL count 0..DATA_WIDTH-1.
REQ-027 tx_en deasserted during any non-IDLE state SHALL NOT abort the frame; the frame completes and no further RD occurs until tx_en=1.
REQ-028 empty rising during RD or LATCH SHALL be ignored; the word is captured as normal.
REQ-029 frame_count SHALL wrap from 0xFFFF to 0x0000 without any flag.

Reset
REQ-030 While rst_n=0, independent of clk_rd, the block SHALL hold: state IDLE, tx=1, rd=0, busy=0, frame_count=0, baud counter=0, bit index=0, shift register=0.
REQ-031 rst_n asserted mid-frame SHALL abort the frame immediately, with tx=1 in the same cycle; the aborted frame SHALL NOT be counted.
REQ-032 After rst_n deasserts, the first RD SHALL occur no earlier than the second rising edge.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless stated)
REQ-033 Single byte, PARITY=0: FIFO holds 0xA5 with tx_en=1 -> one rd pulse; tx=0 three edges later; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; then stop; frame 40 cycles; frame_count=1.
REQ-034 Parity, 0xA5: PARITY=1 -> parity bit 0; PARITY=2 -> parity bit 1; frame 44 cycles in both cases.
REQ-035 Burst: FIFO holds 0x00..0x04 -> five frames; each pair of frames separated by exactly one idle-high cycle; five rd pulses in total; frame_count=5; busy falls after the last stop.
REQ-036 Empty and enable: empty=1 with tx_en=1 for 200 cycles -> no rd, tx=1; then tx_en dropped during DATA of a frame -> the frame completes and no second rd occurs.
REQ-037 Reset mid-frame: rst_n pulsed low in DATA bit 3 -> tx=1 asynchronously, busy=0, frame_count=0; the next frame after release is transmitted intact.
REQ-038 Wrap: frame_count preloaded to 0xFFFF by forcing, then one frame -> 0x0000.
